key_conditioner: RTL
====================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable samples needed to accept a level change (10 ms at 100 MHz; the bench overrides it to 4).
REQ-002 SHALL have parameter CNT_W, default 20, the debounce counter width; DEBOUNCE_CYCLES must be no greater than 2^CNT_W.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port btn_confirm_raw, input, 1 bit: asynchronous, bouncy confirm key.
REQ-006 SHALL have port btn_store_raw, input, 1 bit: asynchronous, bouncy store key.
REQ-007 SHALL have port btn_next_raw, input, 1 bit: asynchronous, bouncy mode/op-select key.
REQ-008 SHALL have port sw_raw, input, 8 bits: asynchronous DIP-switch operand bus.
REQ-009 SHALL have port confirm, output, 1 bit: one-cycle pulse per accepted confirm press.
REQ-010 SHALL have port store, output, 1 bit: one-cycle pulse per accepted store press.
REQ-011 SHALL have port button_press, output, 1 bit: one-cycle pulse per accepted next press.
REQ-012 SHALL have port sw, output, 8 bits: synchronised switch value feeding the calculator operand input.
REQ-013 SHALL have port btn_level, output, 3 bits: debounced held levels {next, store, confirm}, used for LED feedback.

Function
REQ-014 SHALL pass each raw key and each sw_raw bit through a two-flop synchroniser; sw SHALL equal sw_raw delayed by 2 edges.
REQ-015 SHALL give each key its own FSM with one-hot states IDLE, PRESS_CHK, HELD and RELEASE_CHK, plus a CNT_W-bit counter.
REQ-016 In IDLE, a synchronised 1 SHALL move the FSM to PRESS_CHK with the counter cleared.
REQ-017 In PRESS_CHK, a synchronised 1 SHALL increment the counter; when the counter equals DEBOUNCE_CYCLES-1 the FSM SHALL go to HELD and raise a one-cycle internal request; a synchronised 0 SHALL return the FSM to IDLE with the counter cleared.
REQ-018 In HELD, a synchronised 0 SHALL move the FSM to RELEASE_CHK with the counter cleared; a key held indefinitely SHALL produce no repeat requests.
REQ-019 In RELEASE_CHK, DEBOUNCE_CYCLES consecutive synchronised 0 samples SHALL return the FSM to IDLE; any synchronised 1 SHALL return it to HELD.
REQ-020 btn_level[i] SHALL be 1 exactly while key i's FSM is in HELD or RELEASE_CHK.
REQ-021 An arbiter SHALL OR new requests into a 3-bit pending register.
REQ-022 Each cycle the arbiter SHALL emit the highest-priority pending bit (confirm > store > button_press) on a registered output and clear that bit.
REQ-023 At most one of confirm, store and button_press SHALL be high in any cycle, and each pulse SHALL be exactly 1 cycle wide.
REQ-024 A request arriving for a channel whose pending bit is already set SHALL merge with it and produce one pulse only.
REQ-025 Latency from the first edge that samples raw=1 (held stable) to the output pulse, when no other request is pending, SHALL be DEBOUNCE_CYCLES+3 edges.
REQ-026 Simultaneous accepted presses SHALL appear on consecutive cycles in priority order, and none SHALL be lost.

Reset
REQ-027 On reset: synchroniser flops = 0, counters = 0, pending = 0, confirm/store/button_press = 0, sw = 8'h00.
REQ-028 On reset, every key FSM SHALL enter HELD, so btn_level = 3'b111 for the first cycle after reset, and a key held through reset yields no pulse until it is released and pressed again.
REQ-029 A reset during PRESS_CHK or while requests are pending SHALL discard them; no pulse SHALL follow the reset.

Structure
REQ-030 The shared package cal_pkg SHALL hold the key-state one-hot localparams, the default DEBOUNCE_CYCLES, and the priority indices (CONFIRM=0, STORE=1, NEXT=2).
REQ-031 A sub-module key_debounce SHALL contain one key's synchroniser, FSM and counter; key_conditioner SHALL instantiate it 3 times and add the arbiter and the sw synchroniser.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Clean press: btn_store_raw held high for 20 cycles -> exactly one store pulse, 7 edges after the first sampling edge, 1 cycle wide, no other pulse.
REQ-033 Bounce: btn_confirm_raw toggles 1,0,1,0 with 2-cycle phases, then stays high -> exactly one confirm pulse, 7 edges after the final rise.
REQ-034 Simultaneous: all three raw keys rise on the same cycle and stay high -> confirm, store and button_press pulse on 3 consecutive cycles.
REQ-035 Held through reset: btn_next_raw high, reset for 3 cycles, key held 30 more cycles -> no pulse; key released for 10 cycles, then pressed -> one button_press pulse.
REQ-036 Reset mid-debounce: press confirm, assert reset when the counter = 2 -> no confirm pulse, pending = 0.
REQ-037 Switches: sw_raw = 8'hA5 -> sw = 8'hA5 after 2 edges; reset asserted -> sw = 8'h00 on the next edge.

Source files
------------

// File: rtl/cal_pkg.sv
// rtl/cal_pkg.sv - shared key-state encodings, defaults and priority indices
package cal_pkg;

  localparam logic [3:0] KS_IDLE        = 4'b0001;
  localparam logic [3:0] KS_PRESS_CHK   = 4'b0010;
  localparam logic [3:0] KS_HELD        = 4'b0100;
  localparam logic [3:0] KS_RELEASE_CHK = 4'b1000;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_CNT_W           = 20;

  localparam int PRI_CONFIRM = 0;
  localparam int PRI_STORE   = 1;
  localparam int PRI_NEXT    = 2;

  typedef enum logic [3:0] {
    ST_IDLE        = KS_IDLE,
    ST_PRESS_CHK   = KS_PRESS_CHK,
    ST_HELD        = KS_HELD,
    ST_RELEASE_CHK = KS_RELEASE_CHK
  } key_state_t;

endpackage

// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - raw key/switch inputs and conditioned outputs
interface key_conditioner_if;

  logic       btn_confirm_raw;
  logic       btn_store_raw;
  logic       btn_next_raw;
  logic [7:0] sw_raw;
  logic       confirm;
  logic       store;
  logic       button_press;
  logic [7:0] sw;
  logic [2:0] btn_level;

  modport master (
    output btn_confirm_raw, btn_store_raw, btn_next_raw, sw_raw,
    input  confirm, store, button_press, sw, btn_level
  );

  modport slave (
    input  btn_confirm_raw, btn_store_raw, btn_next_raw, sw_raw,
    output confirm, store, button_press, sw, btn_level
  );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key: two-flop synchroniser, debounce FSM and counter
module key_debounce
  import cal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic req,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             key_s;
  key_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], raw};
    end
  end

  assign key_s = sync[1];

  // Starting in HELD means a key down through reset must be released before it counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_HELD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_s) begin
          state_nxt = ST_PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!key_s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
          req       = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!key_s) begin
          state_nxt = ST_RELEASE_CHK;
          cnt_nxt   = '0;
        end
      end
      ST_RELEASE_CHK: begin
        if (key_s) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_HELD;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level = (state == ST_HELD) || (state == ST_RELEASE_CHK);

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - three debounced keys, priority pulse arbiter, switch synchroniser
module key_conditioner
  import cal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input logic               clk,
  input logic               reset,
  key_conditioner_if.slave  kif
);

  logic [2:0] raw;
  logic [2:0] req;
  logic [2:0] level;
  logic [2:0] pending;
  logic [2:0] merged;
  logic [2:0] grant;
  logic [2:0] pulse_q;
  logic [7:0] sw_meta;
  logic [7:0] sw_q;

  assign raw[PRI_CONFIRM] = kif.btn_confirm_raw;
  assign raw[PRI_STORE]   = kif.btn_store_raw;
  assign raw[PRI_NEXT]    = kif.btn_next_raw;

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .req  (req[i]),
      .level(level[i])
    );
  end

  // A fresh request is eligible in the same cycle it arrives, so a lone press costs no extra edge.
  always_comb begin
    merged = pending | req;
    grant  = '0;
    if (merged[PRI_CONFIRM]) begin
      grant[PRI_CONFIRM] = 1'b1;
    end else if (merged[PRI_STORE]) begin
      grant[PRI_STORE] = 1'b1;
    end else if (merged[PRI_NEXT]) begin
      grant[PRI_NEXT] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      pulse_q <= '0;
    end else begin
      pending <= merged & ~grant;
      pulse_q <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_q    <= '0;
    end else begin
      sw_meta <= kif.sw_raw;
      sw_q    <= sw_meta;
    end
  end

  assign kif.confirm      = pulse_q[PRI_CONFIRM];
  assign kif.store        = pulse_q[PRI_STORE];
  assign kif.button_press = pulse_q[PRI_NEXT];
  assign kif.sw           = sw_q;
  assign kif.btn_level    = level;

endmodule
